mixer_nch: RTL

MIXER_NCH -- requirements
Module: mixer_nch

---
 rtl/mixer_nch_pkg.sv | 10 +
 rtl/mixer_nch_sigma_delta1.sv | 27 ++
 rtl/mixer_nch.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mixer_nch_pkg.sv
// Shared definitions for the N-channel mixer: pass sequencing states.
package mixer_nch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        SAT  = 2'd2
    } mix_state_t;

endpackage

// File: rtl/mixer_nch_sigma_delta1.sv
// First-order sigma-delta modulator: the carry out of a DW-bit error
// accumulator becomes the 1-bit DAC stream.
module sigma_delta1 #(
    parameter int DW = 10
) (
    input  logic          clk28,
    input  logic          rst,
    input  logic [DW-1:0] level,
    output logic          dac
);

    logic [DW-1:0] err;
    logic [DW:0]   sum;

    assign sum = {1'b0, err} + {1'b0, level};

    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            err <= '0;
            dac <= 1'b0;
        end else begin
            err <= sum[DW-1:0];
            dac <= sum[DW];
        end
    end

endmodule

// File: rtl/mixer_nch.sv
// N-channel volume mixer: one time-shared multiplier per side accumulates a
// snapshot of all channels, saturates to a DAC level and feeds a modulator.
module mixer_nch
    import mixer_nch_pkg::*;
#(
    parameter int NCH   = 6,
    parameter int IW    = 8,
    parameter int VW    = 4,
    parameter int DW    = 10,
    parameter int SHIFT = 3
) (
    input  logic              clk28,
    input  logic              rst,
    input  logic              sample_stb,
    input  logic [NCH*IW-1:0] ch_data,
    input  logic [NCH*VW-1:0] ch_vol_l,
    input  logic [NCH*VW-1:0] ch_vol_r,
    input  logic [NCH-1:0]    ch_mute,
    output logic              dac_l,
    output logic              dac_r,
    output logic              busy,
    output logic              clip_l,
    output logic              clip_r,
    output logic              overrun
);

    localparam int IXW  = $clog2(NCH);
    localparam int PW   = IW + VW;
    localparam int ACCW = IW + VW + IXW;
    localparam int CW   = (ACCW > DW) ? ACCW : DW;

    mix_state_t state, nxt;

    logic [IXW-1:0]           idx;
    logic [NCH-1:0][IW-1:0]   data_q;
    logic [NCH-1:0][VW-1:0]   vol_l_q;
    logic [NCH-1:0][VW-1:0]   vol_r_q;
    logic [NCH-1:0]           mute_q;
    logic [ACCW-1:0]          acc_l, acc_r;
    logic [DW-1:0]            level_l, level_r;

    logic [PW-1:0] prod_l, prod_r;
    logic [CW-1:0] sh_l, sh_r;
    logic          over_l, over_r;
    logic          last_ch;

    // Single shared multiplier per side, steered by the channel index
    assign prod_l = mute_q[idx] ? '0 : PW'(data_q[idx]) * PW'(vol_l_q[idx]);
    assign prod_r = mute_q[idx] ? '0 : PW'(data_q[idx]) * PW'(vol_r_q[idx]);

    assign sh_l   = CW'(acc_l) >> SHIFT;
    assign sh_r   = CW'(acc_r) >> SHIFT;
    assign over_l = sh_l > CW'({DW{1'b1}});
    assign over_r = sh_r > CW'({DW{1'b1}});

    assign last_ch = (idx == IXW'(NCH - 1));

    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt     = state;
        busy    = 1'b0;
        clip_l  = 1'b0;
        clip_r  = 1'b0;
        case (state)
            IDLE: if (sample_stb) nxt = ACC;
            ACC: begin
                busy = 1'b1;
                if (last_ch) nxt = SAT;
            end
            SAT: begin
                busy   = 1'b1;
                clip_l = over_l;
                clip_r = over_r;
                nxt    = IDLE;
            end
            default: nxt = IDLE;
        endcase
        overrun = busy & sample_stb;
    end

    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            idx     <= '0;
            data_q  <= '0;
            vol_l_q <= '0;
            vol_r_q <= '0;
            mute_q  <= '0;
            acc_l   <= '0;
            acc_r   <= '0;
            level_l <= '0;
            level_r <= '0;
        end else begin
            case (state)
                IDLE: if (sample_stb) begin
                    data_q  <= ch_data;
                    vol_l_q <= ch_vol_l;
                    vol_r_q <= ch_vol_r;
                    mute_q  <= ch_mute;
                    acc_l   <= '0;
                    acc_r   <= '0;
                    idx     <= '0;
                end
                ACC: begin
                    acc_l <= acc_l + ACCW'(prod_l);
                    acc_r <= acc_r + ACCW'(prod_r);
                    idx   <= idx + IXW'(1);
                end
                SAT: begin
                    level_l <= over_l ? {DW{1'b1}} : sh_l[DW-1:0];
                    level_r <= over_r ? {DW{1'b1}} : sh_r[DW-1:0];
                end
                default: ;
            endcase
        end
    end

    sigma_delta1 #(.DW(DW)) u_sd_l (
        .clk28 (clk28),
        .rst   (rst),
        .level (level_l),
        .dac   (dac_l)
    );

    sigma_delta1 #(.DW(DW)) u_sd_r (
        .clk28 (clk28),
        .rst   (rst),
        .level (level_r),
        .dac   (dac_r)
    );

endmodule
